driver_regbank: RTL and testbench
=================================

Name: driver_regbank

Overview:
- Parametrised successor to the driver control register block: slave-bus register file for the vector driver.
- Owns an internal first-word-fall-through (FWFT) address FIFO and a consecutive-address burst generator.
- Holds the control/status registers and NUM_MON saturating address-monitor counters.
- Sits between the host slave bus and the vector-driver address pipeline.

Parameters:
- ADDR_W, 32, slave address width.
- DATA_W, 32, slave data and FIFO word width.
- NUM_MON, 16, number of address-monitor counters (1..64).
- MON_W, 16, monitor counter width (≤ DATA_W).
- FIFO_DEPTH, 16, address FIFO entries (power of 2, ≥ 2).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- slave_addr  in  ADDR_W  byte address
- slave_rd  in  1  read strobe, one cycle per access
- slave_wr  in  1  write strobe, one cycle per access
- slave_data_in  in  DATA_W  write data
- slave_data_out  out  DATA_W  read data
- slave_rd_valid  out  1  read data valid
- slave_wait  out  1  burst in progress; FIFO-data writes dropped
- mon_inc  in  NUM_MON  per-channel increment pulses
- addr_fifo_dout  out  DATA_W  FIFO head
- addr_fifo_valid  out  1  head valid
- addr_fifo_rd  in  1  pop, honoured only when addr_fifo_valid
- run_program  out  1  CTRL[0]
- end_program  out  1  CTRL[1]
- abort_program  out  1  CTRL[2]
- freeze_vector_fifo  out  1  CTRL[4]

Behaviour:
- Reset: every output 0; all registers 0; FIFO empty; state IDLE. Reset is asynchronous and takes effect mid-burst.
- Register map (byte offsets):
  - 0x000 FIFO_DATA: W pushes; R returns last written value.
  - 0x004 CTRL (R/W).
  - 0x008 STATUS: R; W1C on sticky bits.
  - 0x1000+4*i MON[i]: R returns counter zero-extended; any write clears it.
  - Unmapped addresses: R returns 0; W ignored.
- CTRL fields:
  - [0] run, [1] end, [2] abort, [3] freeze_addr_fifo, [4] freeze_vector_fifo.
  - [5] mon_clear_all: self-clearing, always reads 0.
  - [7] send_consec, [15:8] consec_count, [31:16] reserved (read 0).
- STATUS fields:
  - [7:0] fifo level, [8] empty, [9] full.
  - [10] overflow (sticky, W1C), [11] cmd_drop (sticky, W1C), [12] burst busy.
- Reads: slave_data_out registered, valid exactly 1 cycle after slave_rd. slave_rd_valid is a 1-cycle pulse. slave_data_out holds its value otherwise.
- FIFO push path:
  - IDLE with send_consec=0: a FIFO_DATA write pushes slave_data_in.
  - IDLE with send_consec=1 and consec_count=N>0: push base, go to BURST, then push base+1 .. base+N, one per cycle.
  - Increment is DATA_W-bit and wraps at 2^DATA_W.
  - BURST stalls, without advancing, while the FIFO is full and not popping. Return to IDLE after the final push.
  - slave_wait = (state==BURST).
- A FIFO_DATA write while in BURST is dropped and sets cmd_drop. CTRL/STATUS/MON accesses are still serviced during BURST.
- Push while full with no pop: data dropped, overflow set. Push and pop in the same cycle while full: both succeed, level unchanged.
- Pop: when addr_fifo_rd && addr_fifo_valid, the head advances on the next edge. Pop while empty has no effect.
- freeze_addr_fifo=1: addr_fifo_valid forced 0 and pops ignored; pushes continue.
- abort rising edge (CTRL write taking bit 2 from 0 to 1):
  - Flushes the FIFO to empty and forces state to IDLE in the same cycle.
  - Overflow and cmd_drop are not cleared.
- Monitor counters:
  - Increment by 1 on mon_inc[i]; saturate at 2^MON_W-1.
  - Clear (MON write or mon_clear_all) beats an increment in the same cycle; the counter becomes 0.
- A write to STATUS with bits 10/11 set clears them. If a set event occurs in the same cycle, the set wins.

Test Plan:
- Reset: assert reset asynchronously mid-burst → all outputs 0 immediately; STATUS reads 0x100 after release.
- Plain push: write 0x0000_0040 to 0x000 twice, pop twice → dout 0x40 then 0x40, valid drops after the 2nd pop; STATUS level 0.
- Burst: CTRL=0x0000_0380 (send_consec, N=3), write 0xFFFF_FFFE to 0x000 → FIFO holds FFFFFFFE, FFFFFFFF, 00000000, 00000001. slave_wait is high 3 cycles. A FIFO write during wait sets STATUS[11].
- Full/overflow (FIFO_DEPTH=16): 17 pushes → STATUS[9]=1, [10]=1, level 16. Push+pop in the same cycle keeps level 16 with no new overflow. Write 0x400 to STATUS → bit 10 clears.
- Monitors: pulse mon_inc[3] 70000 times (MON_W=16) → MON[3] at 0x100C reads 0xFFFF. Write to 0x100C in the same cycle as mon_inc[3] → reads 0.
- Abort/freeze: fill 5 entries, set CTRL[3] → valid 0 with level 5. Write CTRL=0x4 → level 0, IDLE, run_program 0.

Source files
------------

// File: rtl/driver_regbank.sv
// Slave-bus register bank for the vector driver: control/status registers, an FWFT
// address FIFO fed directly or by a consecutive-address burst generator, and saturating monitors.
module driver_regbank #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_MON    = 16,
    parameter int MON_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   slave_addr,
    input  logic                slave_rd,
    input  logic                slave_wr,
    input  logic [DATA_W-1:0]   slave_data_in,
    output logic [DATA_W-1:0]   slave_data_out,
    output logic                slave_rd_valid,
    output logic                slave_wait,
    input  logic [NUM_MON-1:0]  mon_inc,
    output logic [DATA_W-1:0]   addr_fifo_dout,
    output logic                addr_fifo_valid,
    input  logic                addr_fifo_rd,
    output logic                run_program,
    output logic                end_program,
    output logic                abort_program,
    output logic                freeze_vector_fifo
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] MON_BASE = ADDR_W'(32'h1000);

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    function automatic logic [MON_W-1:0] mon_sat_inc(input logic [MON_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + MON_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  burst_next_q, burst_next_d;
    logic [7:0]         burst_left_q, burst_left_d;

    logic               ctrl_run, ctrl_end, ctrl_abort, ctrl_freeze_addr, ctrl_freeze_vec;
    logic               ctrl_send_consec;
    logic [7:0]         ctrl_consec_count;
    logic [DATA_W-1:0]  last_wr_data;
    logic               sticky_ovf, sticky_drop;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               fifo_full, fifo_empty;

    logic [MON_W-1:0]   mon_cnt [NUM_MON];

    logic               hit_fifo, hit_ctrl, hit_status, mon_range;
    logic [ADDR_W-1:0]  mon_off;
    logic               fifo_wr, ctrl_wr, status_wr;
    logic               abort_rise, mon_clear_all;
    logic               push_req, push_ok, pop_fire, ovf_set, drop_set;
    logic [DATA_W-1:0]  push_data;
    logic [DATA_W-1:0]  ctrl_word, status_word, rd_data_p0;

    assign hit_fifo   = (slave_addr == ADDR_W'(0));
    assign hit_ctrl   = (slave_addr == ADDR_W'(4));
    assign hit_status = (slave_addr == ADDR_W'(8));
    assign mon_off    = slave_addr - MON_BASE;
    assign mon_range  = (slave_addr >= MON_BASE) && (mon_off[1:0] == 2'b00);

    assign fifo_wr    = slave_wr && hit_fifo;
    assign ctrl_wr    = slave_wr && hit_ctrl;
    assign status_wr  = slave_wr && hit_status;
    assign abort_rise = ctrl_wr && slave_data_in[2] && !ctrl_abort;
    assign mon_clear_all = ctrl_wr && slave_data_in[5];

    assign fifo_full       = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty      = (level == '0);
    assign addr_fifo_valid = !fifo_empty && !ctrl_freeze_addr;
    assign addr_fifo_dout  = addr_fifo_valid ? mem[rd_ptr] : '0;
    assign pop_fire        = addr_fifo_rd && addr_fifo_valid;
    assign push_ok         = push_req && (!fifo_full || pop_fire);
    assign ovf_set         = push_req && fifo_full && !pop_fire;

    assign slave_wait         = (state_q == BURST);
    assign run_program        = ctrl_run;
    assign end_program        = ctrl_end;
    assign abort_program      = ctrl_abort;
    assign freeze_vector_fifo = ctrl_freeze_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_next_q <= '0;
            burst_left_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_next_q <= burst_next_d;
            burst_left_q <= burst_left_d;
        end
    end

    // Burst generator: base goes in from the bus write, then base+1..base+N, stalling on a full FIFO.
    always_comb begin
        state_d      = state_q;
        burst_next_d = burst_next_q;
        burst_left_d = burst_left_q;
        push_req     = 1'b0;
        push_data    = slave_data_in;
        drop_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_wr) begin
                    push_req = 1'b1;
                    if (ctrl_send_consec && (ctrl_consec_count != 8'd0)) begin
                        state_d      = BURST;
                        burst_next_d = slave_data_in + DATA_W'(1);
                        burst_left_d = ctrl_consec_count;
                    end
                end
            end
            BURST: begin
                drop_set  = fifo_wr;
                push_data = burst_next_q;
                if (!fifo_full || pop_fire) begin
                    push_req     = 1'b1;
                    burst_next_d = burst_next_q + DATA_W'(1);
                    burst_left_d = burst_left_q - 8'd1;
                    if (burst_left_q == 8'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_rise) begin
            state_d  = IDLE;
            push_req = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_run          <= 1'b0;
            ctrl_end          <= 1'b0;
            ctrl_abort        <= 1'b0;
            ctrl_freeze_addr  <= 1'b0;
            ctrl_freeze_vec   <= 1'b0;
            ctrl_send_consec  <= 1'b0;
            ctrl_consec_count <= '0;
        end else if (ctrl_wr) begin
            ctrl_run          <= slave_data_in[0];
            ctrl_end          <= slave_data_in[1];
            ctrl_abort        <= slave_data_in[2];
            ctrl_freeze_addr  <= slave_data_in[3];
            ctrl_freeze_vec   <= slave_data_in[4];
            ctrl_send_consec  <= slave_data_in[7];
            ctrl_consec_count <= slave_data_in[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_wr_data <= '0;
            sticky_ovf   <= 1'b0;
            sticky_drop  <= 1'b0;
        end else begin
            if (fifo_wr && (state_q == IDLE)) last_wr_data <= slave_data_in;
            if (ovf_set) sticky_ovf <= 1'b1;
            else if (status_wr && slave_data_in[10]) sticky_ovf <= 1'b0;
            if (drop_set) sticky_drop <= 1'b1;
            else if (status_wr && slave_data_in[11]) sticky_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort_rise) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_fire})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // A clear in the same cycle as an increment leaves the counter at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MON; i++) mon_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MON; i++) begin
                if (mon_clear_all ||
                    (slave_wr && mon_range && (mon_off[ADDR_W-1:2] == (ADDR_W-2)'(i))))
                    mon_cnt[i] <= '0;
                else if (mon_inc[i])
                    mon_cnt[i] <= mon_sat_inc(mon_cnt[i]);
            end
        end
    end

    always_comb begin
        ctrl_word       = '0;
        ctrl_word[0]    = ctrl_run;
        ctrl_word[1]    = ctrl_end;
        ctrl_word[2]    = ctrl_abort;
        ctrl_word[3]    = ctrl_freeze_addr;
        ctrl_word[4]    = ctrl_freeze_vec;
        ctrl_word[7]    = ctrl_send_consec;
        ctrl_word[15:8] = ctrl_consec_count;
    end

    always_comb begin
        status_word      = '0;
        status_word[7:0] = 8'(level);
        status_word[8]   = fifo_empty;
        status_word[9]   = fifo_full;
        status_word[10]  = sticky_ovf;
        status_word[11]  = sticky_drop;
        status_word[12]  = (state_q == BURST);
    end

    always_comb begin
        rd_data_p0 = '0;
        if (hit_fifo)        rd_data_p0 = last_wr_data;
        else if (hit_ctrl)   rd_data_p0 = ctrl_word;
        else if (hit_status) rd_data_p0 = status_word;
        else if (mon_range) begin
            for (int i = 0; i < NUM_MON; i++)
                if (mon_off[ADDR_W-1:2] == (ADDR_W-2)'(i)) rd_data_p0[MON_W-1:0] = mon_cnt[i];
        end
    end

    // Read stage p0 -> p1: data registered, valid pulses one cycle after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slave_data_out <= '0;
            slave_rd_valid <= 1'b0;
        end else begin
            slave_rd_valid <= slave_rd;
            if (slave_rd) slave_data_out <= rd_data_p0;
        end
    end

endmodule

// File: tb/tb_driver_regbank.sv
// Scoreboard bench for driver_regbank: expected read data and FIFO contents are queued
// as stimulus is driven and compared when the DUT returns them.
module tb_driver_regbank;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int NUM_MON    = 16;
    localparam int MON_W      = 16;
    localparam int FIFO_DEPTH = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  slave_addr = '0;
    logic               slave_rd = 1'b0;
    logic               slave_wr = 1'b0;
    logic [DATA_W-1:0]  slave_data_in = '0;
    logic [DATA_W-1:0]  slave_data_out;
    logic               slave_rd_valid;
    logic               slave_wait;
    logic [NUM_MON-1:0] mon_inc = '0;
    logic [DATA_W-1:0]  addr_fifo_dout;
    logic               addr_fifo_valid;
    logic               addr_fifo_rd = 1'b0;
    logic               run_program, end_program, abort_program, freeze_vector_fifo;

    always #5 clk = ~clk;

    driver_regbank #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_MON(NUM_MON),
        .MON_W(MON_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .slave_addr(slave_addr), .slave_rd(slave_rd), .slave_wr(slave_wr),
        .slave_data_in(slave_data_in), .slave_data_out(slave_data_out),
        .slave_rd_valid(slave_rd_valid), .slave_wait(slave_wait),
        .mon_inc(mon_inc),
        .addr_fifo_dout(addr_fifo_dout), .addr_fifo_valid(addr_fifo_valid),
        .addr_fifo_rd(addr_fifo_rd),
        .run_program(run_program), .end_program(end_program),
        .abort_program(abort_program), .freeze_vector_fifo(freeze_vector_fifo)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] rd_exp_q[$];
    string             rd_tag_q[$];
    logic [DATA_W-1:0] fifo_model[$];

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_status(input bit ovf, input bit drop, input bit busy);
        logic [DATA_W-1:0] s;
        s       = '0;
        s[7:0]  = 8'(fifo_model.size());
        s[8]    = (fifo_model.size() == 0);
        s[9]    = (fifo_model.size() == FIFO_DEPTH);
        s[10]   = ovf;
        s[11]   = drop;
        s[12]   = busy;
        return s;
    endfunction

    // Read-data scoreboard.
    always @(negedge clk) begin
        if (slave_rd_valid) begin
            if (rd_exp_q.size() == 0) check("rd_unexpected", DATA_W'(1), DATA_W'(0));
            else check(rd_tag_q.pop_front(), slave_data_out, rd_exp_q.pop_front());
        end
    end

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        slave_addr = a; slave_data_in = d; slave_wr = 1'b1;
        @(negedge clk);
        slave_wr = 1'b0;
    endtask

    task automatic fifo_write(input logic [DATA_W-1:0] d);
        bus_write(ADDR_W'(0), d);
        if (fifo_model.size() < FIFO_DEPTH) fifo_model.push_back(d);
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
        @(negedge clk);
        slave_addr = a; slave_rd = 1'b1;
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(tag);
        @(negedge clk);
        slave_rd = 1'b0;
    endtask

    task automatic fifo_pop(input string tag);
        @(negedge clk);
        check({tag, "_vld"}, DATA_W'(addr_fifo_valid), DATA_W'(1));
        if (fifo_model.size() > 0) check(tag, addr_fifo_dout, fifo_model.pop_front());
        addr_fifo_rd = 1'b1;
        @(negedge clk);
        addr_fifo_rd = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdata"}, slave_data_out, '0);
        check({tag, "_rvld"},  DATA_W'(slave_rd_valid), '0);
        check({tag, "_wait"},  DATA_W'(slave_wait), '0);
        check({tag, "_dout"},  addr_fifo_dout, '0);
        check({tag, "_fvld"},  DATA_W'(addr_fifo_valid), '0);
        check({tag, "_run"},   DATA_W'(run_program), '0);
        check({tag, "_end"},   DATA_W'(end_program), '0);
        check({tag, "_abort"}, DATA_W'(abort_program), '0);
        check({tag, "_frzv"},  DATA_W'(freeze_vector_fifo), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        logic [DATA_W-1:0] base;

        #1;
        check_outputs_zero("rst_in");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("rst_out");
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "rst_status");

        // Plain pushes and pops.
        fifo_write(32'h0000_0040);
        fifo_write(32'h0000_0040);
        bus_read(ADDR_W'(0), 32'h0000_0040, "fifo_data_rb");
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "status_lvl2");
        fifo_pop("pop1");
        fifo_pop("pop2");
        check("valid_after_pops", DATA_W'(addr_fifo_valid), '0);
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "status_lvl0");

        // Burst with a wrapping increment and a dropped FIFO write during wait.
        bus_write(ADDR_W'(4), 32'h0000_0380);
        bus_read(ADDR_W'(4), 32'h0000_0380, "ctrl_rb");
        base = 32'hFFFF_FFFE;
        wait_cycles = 0;
        @(negedge clk);
        slave_addr = '0; slave_data_in = base; slave_wr = 1'b1;
        for (int k = 0; k <= 3; k++) fifo_model.push_back(base + DATA_W'(k));
        @(negedge clk);
        slave_wr = 1'b0;
        if (slave_wait) wait_cycles++;
        @(negedge clk);
        if (slave_wait) wait_cycles++;
        slave_data_in = 32'h0000_1234; slave_wr = 1'b1;
        @(negedge clk);
        slave_wr = 1'b0;
        if (slave_wait) wait_cycles++;
        @(negedge clk);
        check("wait_cycles", DATA_W'(wait_cycles), DATA_W'(3));
        check("wait_done", DATA_W'(slave_wait), '0);
        bus_read(ADDR_W'(8), exp_status(0, 1, 0), "burst_status");
        bus_write(ADDR_W'(8), 32'h0000_0800);
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "drop_w1c");
        for (int k = 0; k < 4; k++) fifo_pop("burst_pop");
        bus_write(ADDR_W'(4), '0);

        // Fill past full, clear overflow, then push and pop together while full.
        for (int i = 0; i < 17; i++) fifo_write(DATA_W'(32'h100 + i));
        bus_read(ADDR_W'(8), exp_status(1, 0, 0), "full_ovf");
        bus_write(ADDR_W'(8), 32'h0000_0400);
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "ovf_w1c");
        @(negedge clk);
        check("pushpop_head", addr_fifo_dout, fifo_model.pop_front());
        slave_addr = '0; slave_data_in = 32'h0000_0ABC; slave_wr = 1'b1; addr_fifo_rd = 1'b1;
        fifo_model.push_back(32'h0000_0ABC);
        @(negedge clk);
        slave_wr = 1'b0; addr_fifo_rd = 1'b0;
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "pushpop_status");
        bus_write(ADDR_W'(4), 32'h0000_0004);
        fifo_model.delete();
        bus_write(ADDR_W'(4), '0);
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "flush_status");

        // Freeze, ignored pop, then abort flush.
        for (int i = 0; i < 5; i++) fifo_write(DATA_W'(32'h500 + i));
        bus_write(ADDR_W'(4), 32'h0000_0009);
        check("frz_run", DATA_W'(run_program), DATA_W'(1));
        check("frz_valid", DATA_W'(addr_fifo_valid), '0);
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "frz_level");
        @(negedge clk);
        addr_fifo_rd = 1'b1;
        @(negedge clk);
        addr_fifo_rd = 1'b0;
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "frz_pop_ignored");
        bus_write(ADDR_W'(4), 32'h0000_0004);
        fifo_model.delete();
        check("abort_run", DATA_W'(run_program), '0);
        check("abort_pin", DATA_W'(abort_program), DATA_W'(1));
        check("abort_valid", DATA_W'(addr_fifo_valid), '0);
        check("abort_wait", DATA_W'(slave_wait), '0);
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "abort_status");
        bus_write(ADDR_W'(4), 32'h0000_0010);
        check("frzv_pin", DATA_W'(freeze_vector_fifo), DATA_W'(1));
        bus_write(ADDR_W'(4), 32'h0000_0002);
        check("end_pin", DATA_W'(end_program), DATA_W'(1));
        check("frzv_off", DATA_W'(freeze_vector_fifo), '0);
        bus_write(ADDR_W'(4), '0);

        // Monitor saturation and clear priority.
        @(negedge clk);
        mon_inc = 16'h0008;
        repeat (70000) @(negedge clk);
        mon_inc = '0;
        bus_read(ADDR_W'(32'h100C), 32'h0000_FFFF, "mon3_sat");
        bus_read(ADDR_W'(32'h1008), '0, "mon2_idle");
        @(negedge clk);
        mon_inc = 16'h0008; slave_addr = ADDR_W'(32'h100C); slave_data_in = '0; slave_wr = 1'b1;
        @(negedge clk);
        mon_inc = '0; slave_wr = 1'b0;
        bus_read(ADDR_W'(32'h100C), '0, "mon3_clr_beats_inc");
        @(negedge clk);
        mon_inc = 16'h0008;
        @(negedge clk);
        mon_inc = '0;
        bus_read(ADDR_W'(32'h100C), DATA_W'(1), "mon3_one");
        bus_write(ADDR_W'(4), 32'h0000_0020);
        bus_read(ADDR_W'(32'h100C), '0, "mon_clear_all");
        bus_read(ADDR_W'(4), '0, "ctrl_selfclr");
        bus_read(ADDR_W'(32'h00C), '0, "unmapped");
        bus_read(ADDR_W'(32'h1040), '0, "mon_oob");

        // Asynchronous reset in the middle of a burst.
        bus_write(ADDR_W'(4), 32'h0000_0380);
        bus_read(ADDR_W'(4), 32'h0000_0380, "ctrl_rb2");
        bus_write(ADDR_W'(0), 32'h0000_0010);
        check("mid_burst_wait", DATA_W'(slave_wait), DATA_W'(1));
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        fifo_model.delete();
        bus_read(ADDR_W'(8), exp_status(0, 0, 0), "post_rst_status");
        bus_read(ADDR_W'(4), '0, "post_rst_ctrl");

        repeat (3) @(negedge clk);
        check("rd_q_drained", DATA_W'(rd_exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
